color_classifier: RTL and testbench

//  Front end for one TCS3200-style colour sensor; Top instantiates it twice (object, station).

---
 rtl/color_pkg.sv | 32 +++
 rtl/edge_counter.sv | 45 ++++
 rtl/color_classifier.sv | 193 +++++++++++++++++++
 tb/tb_color_classifier.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/color_pkg.sv
// rtl/color_pkg.sv - colour codes, sensor filter selects and sweep state encoding
package color_pkg;

    localparam logic [1:0] COL_NONE  = 2'd0;
    localparam logic [1:0] COL_RED   = 2'd1;
    localparam logic [1:0] COL_GREEN = 2'd2;
    localparam logic [1:0] COL_BLUE  = 2'd3;

    localparam logic [1:0] SEL_RED   = 2'b00;
    localparam logic [1:0] SEL_GREEN = 2'b11;
    localparam logic [1:0] SEL_BLUE  = 2'b01;

    typedef enum logic [2:0] {
        ST_SET_R  = 3'd0,
        ST_GATE_R = 3'd1,
        ST_SET_G  = 3'd2,
        ST_GATE_G = 3'd3,
        ST_SET_B  = 3'd4,
        ST_GATE_B = 3'd5,
        ST_DECIDE = 3'd6
    } state_t;

    // Filter select presented to the sensor while the sweep sits in a given state.
    function automatic logic [1:0] sel_for(state_t s);
        case (s)
            ST_SET_G, ST_GATE_G: sel_for = SEL_GREEN;
            ST_SET_B, ST_GATE_B: sel_for = SEL_BLUE;
            default:             sel_for = SEL_RED;
        endcase
    endfunction

endpackage

// File: rtl/edge_counter.sv
// rtl/edge_counter.sv - wave synchroniser, rising-edge detect and saturating edge counter
module edge_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wave,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count_next
);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise;
    logic             bump;

    // count_next includes an edge seen this cycle, so the owner can latch it on the final gate cycle.
    always_comb begin
        sync1_d    = wave;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        rise       = sync2_q & ~prev_q;
        bump       = enable & rise & ~(&cnt_q);
        count_next = cnt_q + CNT_W'(bump);
        cnt_d      = clear ? '0 : count_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/color_classifier.sv
// rtl/color_classifier.sv - RGB filter sweep, per-filter edge gating and dominant colour decision
module color_classifier
    import color_pkg::*;
#(
    parameter int SETTLE_CYCLES = 50_000,
    parameter int GATE_CYCLES   = 500_000,
    parameter int CNT_W         = 16,
    parameter int MIN_CNT       = 20,
    parameter int MARGIN        = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wave,
    output logic [1:0]       select,
    output logic [1:0]       color,
    output logic             color_valid,
    output logic [CNT_W-1:0] cnt_r,
    output logic [CNT_W-1:0] cnt_g,
    output logic [CNT_W-1:0] cnt_b
);

    localparam int MAX_CYC = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);
    localparam int WIDE_W  = CNT_W + 4;

    localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0]  GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [WIDE_W-1:0] MIN_W       = WIDE_W'(MIN_CNT);
    localparam logic [WIDE_W-1:0] MARGIN_MUL  = WIDE_W'(8 + MARGIN);

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [1:0]        select_q, select_d;
    logic [1:0]        color_q, color_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  cnt_r_q, cnt_r_d;
    logic [CNT_W-1:0]  cnt_g_q, cnt_g_d;
    logic [CNT_W-1:0]  cnt_b_q, cnt_b_d;

    logic              ec_clear;
    logic              ec_enable;
    logic [CNT_W-1:0]  ec_count_next;

    logic [WIDE_W-1:0] wide_r, wide_g, wide_b;
    logic [WIDE_W-1:0] win, oth_a, oth_b;
    logic [1:0]        winner;
    logic [1:0]        decision;

    edge_counter #(
        .CNT_W (CNT_W)
    ) u_edge_counter (
        .clk        (clk),
        .rst        (rst),
        .wave       (wave),
        .clear      (ec_clear),
        .enable     (ec_enable),
        .count_next (ec_count_next)
    );

    // Widened operands keep win*8 and other*(8+MARGIN) exact even at saturation.
    always_comb begin
        wide_r = WIDE_W'(cnt_r_q);
        wide_g = WIDE_W'(cnt_g_q);
        wide_b = WIDE_W'(cnt_b_q);
        winner = COL_NONE;
        win    = '0;
        oth_a  = '0;
        oth_b  = '0;
        if (wide_r > wide_g && wide_r > wide_b) begin
            winner = COL_RED;
            win    = wide_r;
            oth_a  = wide_g;
            oth_b  = wide_b;
        end else if (wide_g > wide_r && wide_g > wide_b) begin
            winner = COL_GREEN;
            win    = wide_g;
            oth_a  = wide_r;
            oth_b  = wide_b;
        end else if (wide_b > wide_r && wide_b > wide_g) begin
            winner = COL_BLUE;
            win    = wide_b;
            oth_a  = wide_r;
            oth_b  = wide_g;
        end
        decision = winner;
        if (win < MIN_W || (win << 3) < oth_a * MARGIN_MUL || (win << 3) < oth_b * MARGIN_MUL) begin
            decision = COL_NONE;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + TMR_W'(1);
        color_d   = color_q;
        valid_d   = 1'b0;
        cnt_r_d   = cnt_r_q;
        cnt_g_d   = cnt_g_q;
        cnt_b_d   = cnt_b_q;
        ec_clear  = 1'b1;
        ec_enable = 1'b0;
        case (state_q)
            ST_SET_R: begin
                if (timer_q == SETTLE_LAST) begin
                    state_d = ST_GATE_R;
                    timer_d = '0;
                end
            end
            ST_GATE_R: begin
                ec_enable = 1'b1;
                ec_clear  = 1'b0;
                if (timer_q == GATE_LAST) begin
                    cnt_r_d  = ec_count_next;
                    ec_clear = 1'b1;
                    state_d  = ST_SET_G;
                    timer_d  = '0;
                end
            end
            ST_SET_G: begin
                if (timer_q == SETTLE_LAST) begin
                    state_d = ST_GATE_G;
                    timer_d = '0;
                end
            end
            ST_GATE_G: begin
                ec_enable = 1'b1;
                ec_clear  = 1'b0;
                if (timer_q == GATE_LAST) begin
                    cnt_g_d  = ec_count_next;
                    ec_clear = 1'b1;
                    state_d  = ST_SET_B;
                    timer_d  = '0;
                end
            end
            ST_SET_B: begin
                if (timer_q == SETTLE_LAST) begin
                    state_d = ST_GATE_B;
                    timer_d = '0;
                end
            end
            ST_GATE_B: begin
                ec_enable = 1'b1;
                ec_clear  = 1'b0;
                if (timer_q == GATE_LAST) begin
                    cnt_b_d  = ec_count_next;
                    ec_clear = 1'b1;
                    state_d  = ST_DECIDE;
                    timer_d  = '0;
                end
            end
            ST_DECIDE: begin
                color_d = decision;
                valid_d = 1'b1;
                state_d = ST_SET_R;
                timer_d = '0;
            end
            default: begin
                state_d = ST_SET_R;
                timer_d = '0;
            end
        endcase
        select_d = sel_for(state_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_SET_R;
            timer_q  <= '0;
            select_q <= SEL_RED;
            color_q  <= COL_NONE;
            valid_q  <= 1'b0;
            cnt_r_q  <= '0;
            cnt_g_q  <= '0;
            cnt_b_q  <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            select_q <= select_d;
            color_q  <= color_d;
            valid_q  <= valid_d;
            cnt_r_q  <= cnt_r_d;
            cnt_g_q  <= cnt_g_d;
            cnt_b_q  <= cnt_b_d;
        end
    end

    assign select      = select_q;
    assign color       = color_q;
    assign color_valid = valid_q;
    assign cnt_r       = cnt_r_q;
    assign cnt_g       = cnt_g_q;
    assign cnt_b       = cnt_b_q;

endmodule

// File: tb/tb_color_classifier.sv
// tb/tb_color_classifier.sv - self-checking bench for color_classifier against a wave-history reference model
module tb_color_classifier;

    localparam int S     = 10;
    localparam int G     = 100;
    localparam int SEG   = S + G;
    localparam int PER   = 3 * SEG + 1;
    localparam int MINC  = 5;
    localparam int MARG  = 2;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       wave = 1'b0;
    logic [1:0] sel8, col8, sel4, col4;
    logic       val8, val4;
    logic [7:0] cr8, cg8, cb8;
    logic [3:0] cr4, cg4, cb4;

    color_classifier #(
        .SETTLE_CYCLES (S), .GATE_CYCLES (G), .CNT_W (8), .MIN_CNT (MINC), .MARGIN (MARG)
    ) dut8 (
        .clk (clk), .rst (rst), .wave (wave), .select (sel8), .color (col8),
        .color_valid (val8), .cnt_r (cr8), .cnt_g (cg8), .cnt_b (cb8)
    );

    color_classifier #(
        .SETTLE_CYCLES (S), .GATE_CYCLES (G), .CNT_W (4), .MIN_CNT (MINC), .MARGIN (MARG)
    ) dut4 (
        .clk (clk), .rst (rst), .wave (wave), .select (sel4), .color (col4),
        .color_valid (val4), .cnt_r (cr4), .cnt_g (cg4), .cnt_b (cb4)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    int         n = 0;
    int         cyc = 0;
    bit         hist [0:8191];
    int         kind [3];
    int         par [3];
    logic [1:0] exp_sel, exp_col8, exp_col4;
    logic       exp_valid;
    int         exp_r8, exp_g8, exp_b8, exp_r4, exp_g4, exp_b4;

    // Position inside a sweep; 0 is the first SET_R cycle (also the cycle a decision is visible).
    function automatic int pos_of(int k);
        return (k + 1) % PER;
    endfunction

    // kind: 0 square wave of period par, 1 par single-cycle pulses inside the gate, 2 random density par%, 3 low
    function automatic bit gen(int k);
        int p, c, rel;
        p   = pos_of(k);
        c   = (p / SEG > 2) ? 2 : p / SEG;
        rel = p - SEG * c;
        case (kind[c])
            0:       return (k % par[c]) < (par[c] / 2);
            1:       return (rel >= S + 10) && (rel < S + 10 + 2 * par[c]) && (rel % 2 == 0);
            2:       return $urandom_range(0, 99) < par[c];
            default: return 1'b0;
        endcase
    endfunction

    // Rising edges seen by the gate of channel c in the sweep starting at cycle e (2-cycle synchroniser lag).
    function automatic int count_ch(int e, int c);
        int lo, k;
        k  = 0;
        lo = e + S - 1 + SEG * c;
        for (int m = lo; m <= lo + G - 1; m++) begin
            if (hist[m - 1] && !hist[m - 2]) k++;
        end
        return k;
    endfunction

    function automatic int sat(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [1:0] classify(int r, int g, int b);
        int mx, ties, o1, o2;
        logic [1:0] code;
        mx   = (r > g) ? r : g;
        mx   = (b > mx) ? b : mx;
        ties = int'(r == mx) + int'(g == mx) + int'(b == mx);
        if (ties > 1 || mx < MINC) return 2'd0;
        if (r == mx) begin code = 2'd1; o1 = g; o2 = b; end
        else if (g == mx) begin code = 2'd2; o1 = r; o2 = b; end
        else begin code = 2'd3; o1 = r; o2 = g; end
        if (mx * 8 < o1 * (8 + MARG) || mx * 8 < o2 * (8 + MARG)) return 2'd0;
        return code;
    endfunction

    task automatic set_cfg(input int k0, input int p0, input int k1, input int p1, input int k2, input int p2);
        kind[0] = k0; par[0] = p0;
        kind[1] = k1; par[1] = p1;
        kind[2] = k2; par[2] = p2;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        wave = 1'b0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        n         = 0;
        exp_sel   = 2'b00;
        exp_col8  = 2'd0;
        exp_col4  = 2'd0;
        exp_valid = 1'b0;
        exp_r8 = 0; exp_g8 = 0; exp_b8 = 0;
        exp_r4 = 0; exp_g4 = 0; exp_b4 = 0;
    endtask

    task automatic step();
        int p, e;
        wave    = gen(n);
        hist[n] = wave;
        @(posedge clk);
        #1;
        cyc = n;
        n++;
        p = pos_of(cyc);
        exp_sel   = (p < SEG) ? 2'b00 : (p < 2 * SEG) ? 2'b11 : (p < 3 * SEG) ? 2'b01 : 2'b00;
        exp_valid = (p == 0);
        if (exp_valid) begin
            e = cyc - (PER - 1);
            exp_r8 = sat(count_ch(e, 0), 255); exp_r4 = sat(count_ch(e, 0), 15);
            exp_g8 = sat(count_ch(e, 1), 255); exp_g4 = sat(count_ch(e, 1), 15);
            exp_b8 = sat(count_ch(e, 2), 255); exp_b4 = sat(count_ch(e, 2), 15);
            exp_col8 = classify(exp_r8, exp_g8, exp_b8);
            exp_col4 = classify(exp_r4, exp_g4, exp_b4);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (sel8 !== 2'b00) begin miscompares++; $display("FAIL reset_select: got %0d expected 0", sel8); end
        vectors++; if (col8 !== 2'd0) begin miscompares++; $display("FAIL reset_color: got %0d expected 0", col8); end
        vectors++; if (val8 !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0b expected 0", val8); end
        vectors++; if ({cr8, cg8, cb8} !== 24'd0) begin miscompares++; $display("FAIL reset_cnt: got %0h expected 0", {cr8, cg8, cb8}); end
        vectors++; if ({col4, val4, cr4, cg4, cb4} !== 15'd0) begin miscompares++; $display("FAIL reset_w4: got %0h expected 0", {col4, val4, cr4, cg4, cb4}); end
    endtask

    task automatic test_red();
        int pulses = 0;
        do_reset();
        set_cfg(0, 4, 0, 20, 0, 20);
        for (int i = 0; i < PER; i++) begin
            step();
            if (val8) pulses++;
            vectors++; if (val8 !== exp_valid) begin miscompares++; $display("FAIL red_valid cyc %0d: got %0b expected %0b", cyc, val8, exp_valid); end
            vectors++; if (sel8 !== exp_sel) begin miscompares++; $display("FAIL red_select cyc %0d: got %0d expected %0d", cyc, sel8, exp_sel); end
            vectors++; if (col8 !== exp_col8) begin miscompares++; $display("FAIL red_color cyc %0d: got %0d expected %0d", cyc, col8, exp_col8); end
        end
        vectors++; if (cr8 !== 8'd25) begin miscompares++; $display("FAIL red_cnt_r: got %0d expected 25", cr8); end
        vectors++; if (cg8 !== 8'd5) begin miscompares++; $display("FAIL red_cnt_g: got %0d expected 5", cg8); end
        vectors++; if (cb8 !== 8'd5) begin miscompares++; $display("FAIL red_cnt_b: got %0d expected 5", cb8); end
        vectors++; if (col8 !== 2'd1 || val8 !== 1'b1) begin miscompares++; $display("FAIL red_decision at 331: got color %0d valid %0b expected 1 1", col8, val8); end
        vectors++; if (pulses != 1) begin miscompares++; $display("FAIL red_pulses: got %0d expected 1", pulses); end
    endtask

    task automatic test_blue_select();
        int         changes [$];
        int         want [3] = '{109, 219, 329};
        logic [1:0] prev = 2'b00;
        do_reset();
        set_cfg(0, 20, 0, 20, 0, 4);
        for (int i = 0; i < PER; i++) begin
            step();
            if (sel8 !== prev) changes.push_back(cyc);
            prev = sel8;
            vectors++; if (val8 !== exp_valid) begin miscompares++; $display("FAIL blue_valid cyc %0d: got %0b expected %0b", cyc, val8, exp_valid); end
            vectors++; if (sel8 !== exp_sel) begin miscompares++; $display("FAIL blue_select cyc %0d: got %0d expected %0d", cyc, sel8, exp_sel); end
        end
        vectors++; if (changes.size() != 3) begin miscompares++; $display("FAIL blue_sel_changes: got %0d expected 3", changes.size()); end
        for (int i = 0; i < 3 && i < changes.size(); i++) begin
            vectors++; if (changes[i] != want[i]) begin miscompares++; $display("FAIL blue_sel_edge%0d: got %0d expected %0d", i, changes[i] + 1, want[i] + 1); end
        end
        vectors++; if (col8 !== 2'd3 || cb8 !== 8'd25) begin miscompares++; $display("FAIL blue_decision: got color %0d cnt_b %0d expected 3 25", col8, cb8); end
    endtask

    task automatic test_dark();
        int pulses = 0;
        do_reset();
        set_cfg(3, 0, 3, 0, 3, 0);
        for (int i = 0; i < 2 * PER; i++) begin
            step();
            if (val8) pulses++;
            vectors++; if (val8 !== exp_valid) begin miscompares++; $display("FAIL dark_valid cyc %0d: got %0b expected %0b", cyc, val8, exp_valid); end
            vectors++; if (col8 !== 2'd0) begin miscompares++; $display("FAIL dark_color cyc %0d: got %0d expected 0", cyc, col8); end
        end
        vectors++; if ({cr8, cg8, cb8} !== 24'd0) begin miscompares++; $display("FAIL dark_cnt: got %0h expected 0", {cr8, cg8, cb8}); end
        vectors++; if (pulses != 2) begin miscompares++; $display("FAIL dark_pulses: got %0d expected 2", pulses); end
    endtask

    task automatic test_margin();
        do_reset();
        set_cfg(1, 20, 1, 18, 1, 5);
        for (int i = 0; i < 2 * PER; i++) begin
            if (n == PER - 1) par[1] = 16;
            step();
            vectors++; if (col8 !== exp_col8) begin miscompares++; $display("FAIL margin_color cyc %0d: got %0d expected %0d", cyc, col8, exp_col8); end
            if (cyc == PER - 1) begin
                vectors++; if (cr8 !== 8'd20 || cg8 !== 8'd18 || cb8 !== 8'd5) begin miscompares++; $display("FAIL margin_cnt1: got %0d %0d %0d expected 20 18 5", cr8, cg8, cb8); end
                vectors++; if (col8 !== 2'd0) begin miscompares++; $display("FAIL margin_fail: got %0d expected 0", col8); end
            end
        end
        vectors++; if (cr8 !== 8'd20 || cg8 !== 8'd16) begin miscompares++; $display("FAIL margin_cnt2: got %0d %0d expected 20 16", cr8, cg8); end
        vectors++; if (col8 !== 2'd1 || val8 !== 1'b1) begin miscompares++; $display("FAIL margin_equal: got %0d valid %0b expected 1 1", col8, val8); end
    endtask

    task automatic test_saturate();
        do_reset();
        set_cfg(0, 2, 0, 2, 0, 2);
        for (int i = 0; i < PER; i++) begin
            step();
            vectors++; if (val4 !== exp_valid) begin miscompares++; $display("FAIL sat_valid4 cyc %0d: got %0b expected %0b", cyc, val4, exp_valid); end
        end
        vectors++; if (cr4 !== 4'd15 || cg4 !== 4'd15 || cb4 !== 4'd15) begin miscompares++; $display("FAIL sat_cnt4: got %0d %0d %0d expected 15 15 15", cr4, cg4, cb4); end
        vectors++; if (cr8 !== 8'd50 || cg8 !== 8'd50 || cb8 !== 8'd50) begin miscompares++; $display("FAIL sat_cnt8: got %0d %0d %0d expected 50 50 50", cr8, cg8, cb8); end
        vectors++; if (col4 !== 2'd0 || col8 !== 2'd0) begin miscompares++; $display("FAIL sat_tie: got %0d %0d expected 0 0", col4, col8); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_cfg(0, 4, 0, 20, 0, 20);
        for (int i = 0; i < PER + 170; i++) begin
            step();
            vectors++; if (col8 !== exp_col8) begin miscompares++; $display("FAIL mid_color cyc %0d: got %0d expected %0d", cyc, col8, exp_col8); end
        end
        vectors++; if (col8 !== 2'd1 || sel8 !== 2'b11) begin miscompares++; $display("FAIL mid_pre: got color %0d select %0d expected 1 3", col8, sel8); end
        do_reset();
        vectors++; if (col8 !== 2'd0 || sel8 !== 2'b00 || val8 !== 1'b0) begin miscompares++; $display("FAIL mid_after: got color %0d select %0d valid %0b expected 0 0 0", col8, sel8, val8); end
        vectors++; if ({cr8, cg8, cb8} !== 24'd0) begin miscompares++; $display("FAIL mid_cnt: got %0h expected 0", {cr8, cg8, cb8}); end
        for (int i = 0; i < PER; i++) begin
            step();
            vectors++; if (val8 !== exp_valid) begin miscompares++; $display("FAIL mid_valid cyc %0d: got %0b expected %0b", cyc, val8, exp_valid); end
        end
        vectors++; if (col8 !== 2'd1 || val8 !== 1'b1 || cr8 !== 8'd25) begin miscompares++; $display("FAIL mid_redecide: got color %0d valid %0b cnt_r %0d expected 1 1 25", col8, val8, cr8); end
    endtask

    task automatic randomize_cfg();
        for (int c = 0; c < 3; c++) begin
            kind[c] = $urandom_range(0, 3);
            case (kind[c])
                0:       par[c] = $urandom_range(2, 24);
                1:       par[c] = $urandom_range(0, 40);
                2:       par[c] = $urandom_range(0, 70);
                default: par[c] = 0;
            endcase
        end
    endtask

    task automatic test_random();
        do_reset();
        randomize_cfg();
        for (int i = 0; i < 5 * PER; i++) begin
            if (pos_of(n) == 0) randomize_cfg();
            step();
            vectors++; if (val8 !== exp_valid || val4 !== exp_valid) begin miscompares++; $display("FAIL rnd_valid cyc %0d: got %0b %0b expected %0b", cyc, val8, val4, exp_valid); end
            vectors++; if (sel8 !== exp_sel) begin miscompares++; $display("FAIL rnd_select cyc %0d: got %0d expected %0d", cyc, sel8, exp_sel); end
            vectors++; if (col8 !== exp_col8 || col4 !== exp_col4) begin miscompares++; $display("FAIL rnd_color cyc %0d: got %0d %0d expected %0d %0d", cyc, col8, col4, exp_col8, exp_col4); end
            if (exp_valid) begin
                vectors++;
                if (int'(cr8) != exp_r8 || int'(cg8) != exp_g8 || int'(cb8) != exp_b8) begin
                    miscompares++;
                    $display("FAIL rnd_cnt8 cyc %0d: got %0d %0d %0d expected %0d %0d %0d", cyc, cr8, cg8, cb8, exp_r8, exp_g8, exp_b8);
                end
                vectors++;
                if (int'(cr4) != exp_r4 || int'(cg4) != exp_g4 || int'(cb4) != exp_b4) begin
                    miscompares++;
                    $display("FAIL rnd_cnt4 cyc %0d: got %0d %0d %0d expected %0d %0d %0d", cyc, cr4, cg4, cb4, exp_r4, exp_g4, exp_b4);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_red();
        test_blue_select();
        test_dark();
        test_margin();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
